// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network I/O sequencer: FSM states,
// fixed-point constants and the default sample width.
package nn_pkg;

    localparam int NN_DW     = 8;
    localparam int FRAC_BITS = 4;
    localparam int ONE       = 1 << FRAC_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        RUN,
        READ,
        CAPT,
        SEND
    } nn_state_e;

    // A depth of one still needs a 1-bit address bus.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/network_io_controller.sv
// Streams N_IN samples into the network input memory, runs the network via a
// fill/run handshake, then reads back N_OUT results onto a valid/ready stream.
module network_io_controller
    import nn_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    parameter int DW    = NN_DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic signed [DW-1:0]         s_data,
    output logic                         s_ready,
    output logic                         in_trig_w,
    output logic [addr_w(N_IN)-1:0]      in_abus_w,
    output logic signed [DW-1:0]         in_dbus_w,
    output logic                         net_fill,
    output logic                         net_req,
    input  logic                         net_ack_fill,
    input  logic                         net_ack_network,
    output logic                         out_trig_r,
    output logic [addr_w(N_OUT)-1:0]     out_abus_r,
    input  logic signed [DW-1:0]         out_dbus_r,
    output logic                         m_valid,
    output logic signed [DW-1:0]         m_data,
    input  logic                         m_ready,
    output logic                         busy,
    output nn_state_e                    state_dbg_o
);

    localparam int IAW = addr_w(N_IN);
    localparam int OAW = addr_w(N_OUT);
    localparam logic [IAW-1:0] IDX_LAST  = IAW'(N_IN - 1);
    localparam logic [OAW-1:0] RIDX_LAST = OAW'(N_OUT - 1);

    nn_state_e              state_q;
    logic [IAW-1:0]         idx_q;
    logic [OAW-1:0]         ridx_q;
    logic                   net_fill_q;
    logic                   net_req_q;
    logic                   out_trig_q;
    logic                   m_valid_q;
    logic signed [DW-1:0]   m_data_q;
    logic                   accept;

    // Stream handshake: a beat transfers in any cycle where s_valid and
    // s_ready are both high at the rising edge; s_ready is held low in reset.
    assign s_ready   = rst && (state_q == IDLE || state_q == LOAD);
    assign accept    = s_valid && s_ready;
    assign in_trig_w = accept;
    assign in_abus_w = idx_q;
    assign in_dbus_w = s_data;

    assign net_fill    = net_fill_q;
    assign net_req     = net_req_q;
    assign out_trig_r  = out_trig_q;
    assign out_abus_r  = ridx_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg_o = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ridx_q     <= '0;
            net_fill_q <= 1'b0;
            net_req_q  <= 1'b0;
            out_trig_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (N_IN == 1) begin
                            state_q    <= FILL;
                            net_fill_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            idx_q   <= IAW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // idx returns to 0 so the next IDLE beat lands on address 0.
                        if (idx_q == IDX_LAST) begin
                            state_q    <= FILL;
                            net_fill_q <= 1'b1;
                            idx_q      <= '0;
                        end else begin
                            idx_q <= idx_q + IAW'(1);
                        end
                    end
                end
                FILL: begin
                    if (net_ack_fill) begin
                        state_q    <= RUN;
                        net_fill_q <= 1'b0;
                        net_req_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (net_ack_network) begin
                        state_q    <= READ;
                        net_req_q  <= 1'b0;
                        ridx_q     <= '0;
                        out_trig_q <= 1'b1;
                    end
                end
                READ: begin
                    state_q    <= CAPT;
                    out_trig_q <= 1'b0;
                end
                CAPT: begin
                    // Output RAM updates its read register on the falling edge of READ.
                    state_q   <= SEND;
                    m_data_q  <= out_dbus_r;
                    m_valid_q <= 1'b1;
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (ridx_q == RIDX_LAST) begin
                            state_q <= IDLE;
                        end else begin
                            state_q    <= READ;
                            ridx_q     <= ridx_q + OAW'(1);
                            out_trig_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/network_io_controller.md
NETWORK_IO_CONTROLLER -- requirements
Module: network_io_controller

Interface
REQ-001 SHALL have parameter N_IN, default 2, meaning the number of input samples loaded per inference.
REQ-002 SHALL have parameter N_OUT, default 1, meaning the number of output samples returned per inference.
REQ-003 SHALL have parameter DW, default 8, meaning the sample width, signed fixed point with 4 fractional bits (16 = 1.0).
REQ-004 SHALL have ports, in order: clk in 1 (sole clock, rising edge); rst in 1 (reset, asynchronous, active-low).
REQ-005 SHALL have input stream ports: s_valid in 1; s_data in DW signed; s_ready out 1.
REQ-006 SHALL have input-memory write ports: in_trig_w out 1; in_abus_w out clog2(N_IN); in_dbus_w out DW signed.
REQ-007 SHALL have network control ports: net_fill out 1; net_req out 1; net_ack_fill in 1; net_ack_network in 1.
REQ-008 SHALL have output-memory read ports: out_trig_r out 1; out_abus_r out clog2(N_OUT); out_dbus_r in DW signed (memory registers read data on falling clk).
REQ-009 SHALL have result stream ports: m_valid out 1; m_data out DW signed; m_ready in 1; busy out 1 (high when not IDLE).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, FILL, RUN, READ, CAPT, SEND.
REQ-011 IDLE: s_ready=1; an accepted beat (s_valid&s_ready) SHALL write s_data to address 0 in the same cycle (in_trig_w=1, combinational from the handshake) and go to LOAD with idx=1; if N_IN=1, go to FILL instead.
REQ-012 LOAD: s_ready=1; each accepted beat SHALL write address idx and increment idx; the beat writing address N_IN-1 SHALL move the FSM to FILL.
REQ-013 FILL: net_fill SHALL be held at 1 until net_ack_fill is sampled 1, then go to RUN; s_ready=0.
REQ-014 RUN: net_req SHALL be held at 1 until net_ack_network is sampled 1, then go to READ with ridx=0.
REQ-015 READ: out_trig_r=1 and out_abus_r=ridx for exactly one cycle, then go to CAPT.
REQ-016 CAPT: out_dbus_r SHALL be registered into m_data, then go to SEND; read latency is 2 cycles from the READ entry to m_valid.
REQ-017 SEND: m_valid=1 with m_data stable until m_ready; on the handshake, if ridx=N_OUT-1 go to IDLE, else increment ridx and go to READ.
REQ-018 m_valid SHALL be low in every state except SEND; net_fill and net_req SHALL never be high together.
REQ-019 Counters SHALL NOT wrap: idx is bounded by N_IN-1 and ridx by N_OUT-1; no address beyond these bounds SHALL be driven.
REQ-020 s_data SHALL pass to in_dbus_w unmodified, with no saturation or scaling.
REQ-021 net_ack_fill or net_ack_network asserted outside its own state SHALL be ignored.
REQ-022 The back-to-back case SHALL work: an s_valid beat presented in the cycle SEND returns to IDLE is accepted in the following cycle; throughput is one inference per loop.

Reset
REQ-023 rst low SHALL asynchronously force IDLE, idx=0, ridx=0, m_data=0, and all strobes, m_valid, net_fill, net_req and busy to 0; s_ready SHALL be 1 after release.
REQ-024 Reset mid-operation SHALL discard the partial load or result; memory contents are not cleared.

Structure
REQ-025 The FSM state enum, the fixed-point constants (FRAC_BITS=4, ONE=16) and the DW default SHALL live in a shared package nn_pkg.
REQ-026 The block SHALL be flat with no sub-module; the instantiating top connects it to the input ROM/RAM write port, the network and the output RAM.

Verification
REQ-027 XOR (1,1): s_data 16,16, network model writes 0 -> in_abus_w 0,1 with in_dbus_w 16,16; net_fill, then net_req; m_data=0 exactly once.
REQ-028 XOR (0,1): s_data 0,16, model writes 16 -> m_valid with m_data=16; busy falls 1 cycle after the m_ready handshake.
REQ-029 Backpressure: m_ready held low for 5 cycles -> m_valid and m_data=16 stable throughout; exactly one handshake.
REQ-030 Delayed acknowledge: net_ack_fill after 7 cycles and a spurious net_ack_network during FILL -> FSM stays in FILL, net_req stays 0, and RUN is entered only after net_ack_fill.
REQ-031 Reset mid-LOAD (after 1 beat) -> all outputs 0 asynchronously; the next 2 beats write addresses 0,1.
REQ-032 N_OUT=3 build: model outputs 16,-16,0 -> out_abus_r 0,1,2 in order; m_data 16,-16,0.
